// File: rtl/streaming_conditional_subtractor_if.sv
// Block-stream bundle between the comparator stage, the conditional subtractor and its consumer.
// The master drives operand blocks in and takes result blocks out; the slave is the subtractor.
interface streaming_conditional_subtractor_if #(
   parameter int unsigned REGISTER_SIZE = 32
);
   logic                     valid_in;
   logic [REGISTER_SIZE-1:0] block_numA_in;
   logic [REGISTER_SIZE-1:0] block_numB_in;
   logic [1:0]               comparison_result_in;
   logic                     end_comparison_signal_in;
   logic                     ready_out;
   logic                     valid_out;
   logic [REGISTER_SIZE-1:0] data_out;
   logic                     last_out;
   logic                     sync_error_out;

   modport master (
      output valid_in, block_numA_in, block_numB_in, comparison_result_in,
             end_comparison_signal_in,
      input  ready_out, valid_out, data_out, last_out, sync_error_out
   );

   modport slave (
      input  valid_in, block_numA_in, block_numB_in, comparison_result_in,
             end_comparison_signal_in,
      output ready_out, valid_out, data_out, last_out, sync_error_out
   );
endinterface

// File: rtl/streaming_conditional_subtractor.sv
// Buffers LSB-first operand blocks A and B, then streams out A-B when the comparator reported
// A>=B, otherwise A unchanged, one block per cycle with a ripple borrow between blocks.
module streaming_conditional_subtractor #(
   parameter int unsigned REGISTER_SIZE = 32,
   parameter int unsigned NUM_BLOCKS    = 128
) (
   input logic                                clk_in,
   input logic                                rst_n_in,
   streaming_conditional_subtractor_if.slave  io_bus
);
   localparam int unsigned CW  = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;
   localparam int unsigned OCW = CW + 1;
   localparam logic [CW-1:0]  LastIdx = CW'(NUM_BLOCKS - 1);
   localparam logic [OCW-1:0] EndIdx  = OCW'(NUM_BLOCKS);

   typedef enum logic {StLoad, StEmit} state_e;

   state_e                   r_state;
   state_e                   w_state_next;
   logic                     w_ready;
   logic                     r_run;
   logic [CW-1:0]            r_in_count;
   logic [OCW-1:0]           r_out_count;
   logic                     r_sub_en;
   logic                     r_sync_error;
   logic                     r_borrow;
   logic                     r_rd_valid;
   logic                     r_rd_last;
   logic [REGISTER_SIZE-1:0] r_rd_a;
   logic [REGISTER_SIZE-1:0] r_rd_b;
   logic                     r_valid_out;
   logic                     r_last_out;
   logic [REGISTER_SIZE-1:0] r_data_out;
   logic [REGISTER_SIZE-1:0] r_buf_a [NUM_BLOCKS];
   logic [REGISTER_SIZE-1:0] r_buf_b [NUM_BLOCKS];
   logic                     w_accept;
   logic                     w_in_last;
   logic                     w_out_done;
   logic [REGISTER_SIZE:0]   w_diff;

   // Reset release is retimed so the first block lands on the second edge after release.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) r_run <= 1'b0;
      else           r_run <= 1'b1;
   end

   assign w_in_last  = (r_in_count == LastIdx);
   assign w_accept   = io_bus.valid_in && w_ready && r_run;
   assign w_out_done = (r_out_count == EndIdx);

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) r_state <= StLoad;
      else           r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StLoad:  if (w_accept && w_in_last) w_state_next = StEmit;
         StEmit:  if (w_out_done) w_state_next = StLoad;
         default: w_state_next = StLoad;
      endcase
   end

   always_comb begin
      w_ready = (r_state == StLoad);
   end

   always_ff @(posedge clk_in) begin
      if (w_accept) begin
         r_buf_a[r_in_count] <= io_bus.block_numA_in;
         r_buf_b[r_in_count] <= io_bus.block_numB_in;
      end
   end

   // Load counting, result latch and the buffer read stage.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_in_count   <= '0;
         r_out_count  <= '0;
         r_sub_en     <= 1'b0;
         r_sync_error <= 1'b0;
         r_rd_valid   <= 1'b0;
         r_rd_last    <= 1'b0;
         r_rd_a       <= '0;
         r_rd_b       <= '0;
      end else begin
         r_rd_valid <= 1'b0;
         r_rd_last  <= 1'b0;
         if (w_accept) begin
            if (io_bus.end_comparison_signal_in != w_in_last) r_sync_error <= 1'b1;
            if (w_in_last) begin
               r_in_count <= '0;
               r_sub_en   <= (io_bus.comparison_result_in == 2'b10) ||
                             (io_bus.comparison_result_in == 2'b11);
            end else begin
               r_in_count <= r_in_count + 1'b1;
            end
         end
         if (r_state == StEmit) begin
            if (w_out_done) begin
               r_out_count <= '0;
            end else begin
               r_rd_a      <= r_buf_a[r_out_count[CW-1:0]];
               r_rd_b      <= r_buf_b[r_out_count[CW-1:0]];
               r_rd_valid  <= 1'b1;
               r_rd_last   <= (r_out_count[CW-1:0] == LastIdx);
               r_out_count <= r_out_count + 1'b1;
            end
         end
      end
   end

   assign w_diff = {1'b0, r_rd_a} - {1'b0, r_rd_b} - {{REGISTER_SIZE{1'b0}}, r_borrow};

   // Output register; the MSB of the widened difference is the borrow into the next block.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         r_valid_out <= 1'b0;
         r_last_out  <= 1'b0;
         r_data_out  <= '0;
         r_borrow    <= 1'b0;
      end else begin
         r_valid_out <= r_rd_valid;
         r_last_out  <= r_rd_last;
         if (w_accept && w_in_last) begin
            r_borrow <= 1'b0;
         end else if (r_rd_valid) begin
            if (r_sub_en) begin
               {r_borrow, r_data_out} <= w_diff;
            end else begin
               r_data_out <= r_rd_a;
               r_borrow   <= 1'b0;
            end
         end
      end
   end

   assign io_bus.ready_out      = w_ready;
   assign io_bus.valid_out      = r_valid_out;
   assign io_bus.data_out       = r_data_out;
   assign io_bus.last_out       = r_last_out;
   assign io_bus.sync_error_out = r_sync_error;
endmodule

// File: tb/tb_streaming_conditional_subtractor.sv
// Directed and randomized checks of the conditional subtractor against a whole-operand
// arithmetic reference (REGISTER_SIZE=8, NUM_BLOCKS=4).
module tb_streaming_conditional_subtractor;
   localparam int unsigned RS = 8;
   localparam int unsigned NB = 4;
   localparam int unsigned W  = RS * NB;

   logic        clk_in = 1'b0;
   logic        rst_n_in;
   int unsigned cyc    = 0;
   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   int unsigned acc_f1, acc_l1, acc_f2, acc_l2;
   logic [W-1:0] ra, rb;
   logic [NB-1:0] rgaps;

   streaming_conditional_subtractor_if #(.REGISTER_SIZE(RS)) bus ();

   streaming_conditional_subtractor #(
      .REGISTER_SIZE (RS),
      .NUM_BLOCKS    (NB)
   ) dut (
      .clk_in   (clk_in),
      .rst_n_in (rst_n_in),
      .io_bus   (bus)
   );

   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_miss++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Comparator result over the low nblk blocks of each operand.
   function automatic logic [1:0] cmp_code(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input int unsigned nblk);
      logic [63:0] m, ma, mb;
      m  = (64'd1 << (RS * nblk)) - 64'd1;
      ma = {32'd0, a} & m;
      mb = {32'd0, b} & m;
      if (ma < mb) return 2'b01;
      if (ma > mb) return 2'b10;
      return 2'b11;
   endfunction

   function automatic logic [W-1:0] ref_out(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [1:0] code);
      return (code == 2'b10 || code == 2'b11) ? a - b : a;
   endfunction

   task automatic drive_op(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [1:0] code_last, input logic [NB-1:0] gaps,
                           input int force_end_idx,
                           output int unsigned acc_first, output int unsigned acc_last);
      int unsigned guard;
      acc_first = 0;
      acc_last  = 0;
      for (int i = 0; i < int'(NB); i++) begin
         bus.valid_in                 = 1'b1;
         bus.block_numA_in            = a[RS*i +: RS];
         bus.block_numB_in            = b[RS*i +: RS];
         bus.comparison_result_in     = (i == int'(NB) - 1) ? code_last :
                                        cmp_code(a, b, i + 1);
         bus.end_comparison_signal_in = (i == int'(NB) - 1) || (i == force_end_idx);
         guard = 0;
         while (bus.ready_out !== 1'b1 && guard < 50) begin
            @(posedge clk_in); #1;
            guard++;
         end
         check("ready_wait", W'(bus.ready_out), 32'd1);
         @(posedge clk_in); #1;
         if (i == 0) acc_first = cyc;
         acc_last = cyc;
         if (gaps[i] && i < int'(NB) - 1) begin
            bus.valid_in = 1'b0;
            @(posedge clk_in); #1;
         end
      end
      bus.valid_in                 = 1'b0;
      bus.end_comparison_signal_in = 1'b0;
   endtask

   task automatic collect(input string tag, input logic [W-1:0] exp, input int unsigned acc_last);
      int unsigned guard;
      guard = 0;
      while (bus.valid_out !== 1'b1 && guard < 20) begin
         @(posedge clk_in); #1;
         guard++;
      end
      check({tag, "_latency"}, W'(cyc - acc_last), 32'd2);
      for (int j = 0; j < int'(NB); j++) begin
         check({tag, "_valid"}, W'(bus.valid_out), 32'd1);
         check({tag, "_data"}, W'(bus.data_out), W'(exp[RS*j +: RS]));
         check({tag, "_last"}, W'(bus.last_out), W'(j == int'(NB) - 1));
         check({tag, "_ready"}, W'(bus.ready_out), W'(j == int'(NB) - 1));
         @(posedge clk_in); #1;
      end
      check({tag, "_valid_drop"}, W'(bus.valid_out), 32'd0);
   endtask

   task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [NB-1:0] gaps);
      int unsigned af, al;
      logic [1:0] code;
      code = cmp_code(a, b, NB);
      drive_op(a, b, code, gaps, -1, af, al);
      collect(tag, ref_out(a, b, code), al);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      rst_n_in                     = 1'b0;
      bus.valid_in                 = 1'b0;
      bus.block_numA_in            = '0;
      bus.block_numB_in            = '0;
      bus.comparison_result_in     = 2'b00;
      bus.end_comparison_signal_in = 1'b0;
      repeat (3) @(posedge clk_in);
      #1;
      check("rst_ready", W'(bus.ready_out), 32'd1);
      check("rst_valid", W'(bus.valid_out), 32'd0);
      check("rst_data", W'(bus.data_out), 32'd0);
      check("rst_last", W'(bus.last_out), 32'd0);
      check("rst_sync", W'(bus.sync_error_out), 32'd0);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      @(posedge clk_in); #1;

      run_op("subtract", 32'h01000005, 32'h01000003, 4'b0000);
      run_op("borrow", 32'h00000100, 32'h00000001, 4'b0000);
      run_op("pass", 32'h00302010, 32'h01000000, 4'b0000);
      run_op("equal", 32'h55AA55AA, 32'h55AA55AA, 4'b0000);
      drive_op(32'h00000009, 32'h00000003, 2'b00, 4'b0000, -1, acc_f1, acc_l1);
      collect("null_code", 32'h00000009, acc_l1);
      run_op("gaps", 32'h01000005, 32'h01000003, 4'b0011);

      // Next operation held valid during EMIT, accepted as soon as ready returns.
      drive_op(32'h00302010, 32'h01000000, 2'b01, 4'b0000, -1, acc_f1, acc_l1);
      fork
         collect("overlap1", 32'h00302010, acc_l1);
         drive_op(32'hCAFE1234, 32'h0BAD0FFF, 2'b10, 4'b0000, -1, acc_f2, acc_l2);
      join
      check("overlap_accept", W'(acc_f2), W'(acc_l1 + NB + 2));
      collect("overlap2", 32'hCAFE1234 - 32'h0BAD0FFF, acc_l2);

      for (int k = 0; k < 8; k++) begin
         ra    = $urandom;
         rb    = ($urandom_range(0, 3) == 0) ? ra : $urandom;
         rgaps = NB'($urandom_range(0, 7));
         run_op("random", ra, rb, rgaps);
      end
      check("sync_clean", W'(bus.sync_error_out), 32'd0);

      drive_op(32'h00000300, 32'h00000200, 2'b10, 4'b0000, 1, acc_f1, acc_l1);
      check("sync_set", W'(bus.sync_error_out), 32'd1);
      collect("sync_op", 32'h00000100, acc_l1);
      run_op("after_sync", 32'h12345678, 32'h02040608, 4'b0000);
      check("sync_sticky", W'(bus.sync_error_out), 32'd1);

      drive_op(32'h77665544, 32'h11223344, 2'b10, 4'b0000, -1, acc_f1, acc_l1);
      @(posedge clk_in); #1;
      @(posedge clk_in); #1;
      check("pre_reset_valid", W'(bus.valid_out), 32'd1);
      rst_n_in = 1'b0;
      #1;
      check("midemit_valid", W'(bus.valid_out), 32'd0);
      check("midemit_ready", W'(bus.ready_out), 32'd1);
      check("midemit_last", W'(bus.last_out), 32'd0);
      check("midemit_sync", W'(bus.sync_error_out), 32'd0);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk_in); #1;
         check("post_reset_quiet", W'(bus.valid_out), 32'd0);
      end
      run_op("post_reset", 32'h80000000, 32'h00000001, 4'b0101);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
